// File: rtl/seq_pattern_gen_if.sv
// Handshake/bus bundle for the serial pattern transmitter.
// master = the side that requests runs and accepts bits; slave = the transmitter.
interface seq_pattern_gen_if #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 8
) ();
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               start;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic [CNT_W-1:0]   repeat_cnt;
  logic [CNT_W-1:0]   gap;
  logic               ready;
  logic               dout;
  logic               dout_vld;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output start, pattern, len, repeat_cnt, gap, ready,
    input  dout, dout_vld, busy, done, err
  );

  modport slave (
    input  start, pattern, len, repeat_cnt, gap, ready,
    output dout, dout_vld, busy, done, err
  );
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter: sends a 1..MAX_LEN-bit pattern MSB-first,
// repeated repeat_cnt times with optional zero-bit gaps, under a ready handshake.
module seq_pattern_gen #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_pattern_gen_if.slave     bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t             r_state;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_gap;
  logic [CNT_W-1:0]   r_rep_left;
  logic [CNT_W-1:0]   r_gap_left;
  logic [LEN_W-1:0]   r_bit_idx;
  logic               r_dout;
  logic               r_dout_vld;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  logic               w_args_bad;
  logic               w_xfer;

  // Bit select with an index wider than the pattern needs.
  function automatic logic pick_bit(input logic [MAX_LEN-1:0] pat,
                                    input logic [LEN_W-1:0]   idx);
    logic b;
    b = 1'b0;
    for (int i = 0; i < MAX_LEN; i++)
      if (idx == LEN_W'(i)) b = pat[i];
    return b;
  endfunction

  assign w_args_bad = (bus.len == '0) || (bus.len > LEN_W'(MAX_LEN)) ||
                      (bus.repeat_cnt == '0);
  assign w_xfer     = r_dout_vld && bus.ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_dout     <= 1'b0;
      r_dout_vld <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            if (w_args_bad) begin
              r_err <= 1'b1;
            end else begin
              r_pattern  <= bus.pattern;
              r_len      <= bus.len;
              r_gap      <= bus.gap;
              r_rep_left <= bus.repeat_cnt;
              r_bit_idx  <= bus.len - 1'b1;
              r_dout     <= pick_bit(bus.pattern, bus.len - 1'b1);
              r_dout_vld <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (w_xfer) begin
            if (r_bit_idx != '0) begin
              r_bit_idx <= r_bit_idx - 1'b1;
              r_dout    <= pick_bit(r_pattern, r_bit_idx - 1'b1);
            end else if (r_rep_left == CNT_W'(1)) begin
              r_dout     <= 1'b0;
              r_dout_vld <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= IDLE;
            end else begin
              r_rep_left <= r_rep_left - 1'b1;
              if (r_gap != '0) begin
                r_gap_left <= r_gap;
                r_dout     <= 1'b0;
                r_state    <= GAP;
              end else begin
                r_bit_idx <= r_len - 1'b1;
                r_dout    <= pick_bit(r_pattern, r_len - 1'b1);
              end
            end
          end
        end
        GAP: begin
          if (w_xfer) begin
            if (r_gap_left == CNT_W'(1)) begin
              r_bit_idx <= r_len - 1'b1;
              r_dout    <= pick_bit(r_pattern, r_len - 1'b1);
              r_state   <= SHIFT;
            end else begin
              r_gap_left <= r_gap_left - 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.dout     = r_dout;
  assign bus.dout_vld = r_dout_vld;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: expected bit streams are built from the pattern,
// repetition and gap rules, then compared bit by bit under varied ready patterns.
module tb_seq_pattern_gen;
  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  seq_pattern_gen_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

  seq_pattern_gen #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic idle_inputs();
    bus.start      = 1'b0;
    bus.pattern    = '0;
    bus.len        = '0;
    bus.repeat_cnt = '0;
    bus.gap        = '0;
    bus.ready      = 1'b1;
  endtask

  // mode 0: ready always 1; mode 1: random ready; mode 2: 3 stall cycles on 2nd bit
  task automatic test_stream(input string nm, input logic [15:0] pat, input int ln,
                             input int rp, input int gp, input int mode);
    logic q[$];
    int idx, cyc, stall, budget;
    q = {};
    for (int r = 0; r < rp; r++) begin
      for (int b = ln - 1; b >= 0; b--) q.push_back(pat[b]);
      if (r < rp - 1) for (int g = 0; g < gp; g++) q.push_back(1'b0);
    end
    @(negedge clk);
    bus.pattern = pat; bus.len = 5'(ln); bus.repeat_cnt = 8'(rp); bus.gap = 8'(gp);
    bus.ready = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.pattern = 16'($urandom); bus.len = 5'($urandom_range(0, 17));
    bus.repeat_cnt = 8'($urandom); bus.gap = 8'($urandom);
    idx = 0; cyc = 0; stall = 0; budget = 4 * q.size() + 50;
    while (idx < q.size() && cyc < budget) begin
      checks++;
      if (bus.dout_vld !== 1'b1 || bus.busy !== 1'b1 || bus.dout !== q[idx] ||
          bus.done !== 1'b0 || bus.err !== 1'b0) begin
        failures++;
        $display("FAIL %s bit%0d: dout=%b vld=%b busy=%b done=%b err=%b required dout=%b vld=1 busy=1 done=0 err=0",
                 nm, idx, bus.dout, bus.dout_vld, bus.busy, bus.done, bus.err, q[idx]);
      end
      if (mode == 1) bus.ready = ($urandom_range(0, 3) != 0);
      else if (mode == 2 && idx == 1 && stall < 3) begin bus.ready = 1'b0; stall++; end
      else bus.ready = 1'b1;
      if (bus.ready) idx++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (idx < q.size()) begin
      failures++;
      $display("FAIL %s timeout: transferred=%0d required=%0d", nm, idx, q.size());
    end
    if (mode == 2) begin
      checks++;
      if (stall != 3 || cyc != q.size() + 3) begin
        failures++;
        $display("FAIL %s stall cycles: cycles=%0d required=%0d", nm, cyc, q.size() + 3);
      end
    end
    bus.ready = 1'b1;
    checks++;
    if (bus.done !== 1'b1 || bus.dout_vld !== 1'b0 || bus.busy !== 1'b0 || bus.dout !== 1'b0) begin
      failures++;
      $display("FAIL %s completion: done=%b vld=%b busy=%b dout=%b required done=1 vld=0 busy=0 dout=0",
               nm, bus.done, bus.dout_vld, bus.busy, bus.dout);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.dout_vld !== 1'b0) begin
      failures++;
      $display("FAIL %s done_pulse: done=%b vld=%b required done=0 vld=0", nm, bus.done, bus.dout_vld);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.dout, bus.dout_vld, bus.busy, bus.done, bus.err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_state: outs=%b required=00000",
               {bus.dout, bus.dout_vld, bus.busy, bus.done, bus.err});
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    test_stream("all_ones", 16'hF, 4, 3, 0, 0);
    test_stream("gap2", 16'b101, 3, 2, 2, 0);
    test_stream("gap2_stall", 16'b101, 3, 2, 2, 2);
    test_stream("max_len", 16'hA5C3, 16, 2, 1, 0);
    test_stream("len1_max_rep", 16'h1, 1, 255, 0, 0);
  endtask

  task automatic test_errors();
    int bad_len[3]; int bad_rep[3];
    bad_len = '{0, 4, 17}; bad_rep = '{1, 0, 1};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.pattern = 16'hFFFF; bus.len = 5'(bad_len[k]); bus.repeat_cnt = 8'(bad_rep[k]);
      bus.gap = '0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if (bus.err !== 1'b1 || bus.dout_vld !== 1'b0 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL err_case%0d: err=%b vld=%b busy=%b required err=1 vld=0 busy=0",
                 k, bus.err, bus.dout_vld, bus.busy);
      end
      @(negedge clk);
      checks++;
      if (bus.err !== 1'b0 || bus.dout_vld !== 1'b0 || bus.done !== 1'b0) begin
        failures++;
        $display("FAIL err_case%0d_after: err=%b vld=%b done=%b required 0 0 0",
                 k, bus.err, bus.dout_vld, bus.done);
      end
    end
  endtask

  task automatic test_abort();
    logic [15:0] pat;
    pat = 16'h00B6;
    @(negedge clk);
    bus.pattern = pat; bus.len = 5'd8; bus.repeat_cnt = 8'd4; bus.gap = 8'd1;
    bus.ready = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.dout_vld !== 1'b1 || bus.dout !== pat[7 - i]) begin
        failures++;
        $display("FAIL abort_bit%0d: dout=%b vld=%b required dout=%b vld=1",
                 i, bus.dout, bus.dout_vld, pat[7 - i]);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.dout, bus.dout_vld, bus.busy, bus.done, bus.err} !== 5'b0) begin
      failures++;
      $display("FAIL abort_outputs: outs=%b required=00000",
               {bus.dout, bus.dout_vld, bus.busy, bus.done, bus.err});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.dout_vld !== 1'b0) begin
        failures++;
        $display("FAIL abort_quiet%0d: done=%b vld=%b required 0 0", i, bus.done, bus.dout_vld);
      end
    end
    test_stream("after_abort", 16'h00C9, 8, 2, 0, 1);
  endtask

  task automatic test_back_to_back();
    logic exp_vld[7]; logic exp_dout[7]; logic exp_done[7];
    exp_vld  = '{1, 1, 0, 1, 1, 0, 0};
    exp_dout = '{1, 0, 0, 1, 0, 0, 0};
    exp_done = '{0, 0, 1, 0, 0, 1, 0};
    @(negedge clk);
    bus.pattern = 16'b10; bus.len = 5'd2; bus.repeat_cnt = 8'd1; bus.gap = 8'd0;
    bus.ready = 1'b1; bus.start = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 3) bus.start = 1'b0;
      checks++;
      if (bus.dout_vld !== exp_vld[c] || bus.dout !== exp_dout[c] ||
          bus.done !== exp_done[c] || bus.err !== 1'b0) begin
        failures++;
        $display("FAIL b2b_cycle%0d: vld=%b dout=%b done=%b err=%b required vld=%b dout=%b done=%b err=0",
                 c, bus.dout_vld, bus.dout, bus.done, bus.err, exp_vld[c], exp_dout[c], exp_done[c]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++)
      test_stream("random", 16'($urandom), $urandom_range(1, 16), $urandom_range(1, 4),
                  $urandom_range(0, 3), (n % 2 == 0) ? 1 : 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_abort();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
